bus_datos_rtc: RTL and testbench

BUS_DATOS_RTC -- requirements
Module: bus_datos_rtc

---
 rtl/bus_datos_rtc_pkg.sv | 25 ++
 rtl/bus_datos_rtc.sv | 112 +++++++++++
 tb/tb_bus_datos_rtc.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_datos_rtc_pkg.sv
// Shared constants for the RTC multiplexed address/data bus.
// Contents: cont_32 window limits and the command state encoding.
package bus_datos_rtc_pkg;

  localparam logic [4:0] DIR_INI  = 5'd1;
  localparam logic [4:0] DIR_FIN  = 5'd11;
  localparam logic [4:0] DATO_INI = 5'd19;
  localparam logic [4:0] DATO_FIN = 5'd28;
  localparam logic [4:0] MUESTRA  = 5'd26;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DIRECCION = 3'd1,
    ESPERA    = 3'd2,
    DATO      = 3'd3,
    FIN       = 3'd4
  } estado_t;

  function automatic logic en_ventana(input logic [4:0] c,
                                      input logic [4:0] ini,
                                      input logic [4:0] fin);
    return (c >= ini) && (c <= fin);
  endfunction

endpackage

// File: rtl/bus_datos_rtc.sv
// RTC multiplexed AD-bus sequencer: one command per 32-cycle frame; pad outputs decode state and cont_32 combinationally, read data is ready one cycle after MUESTRA.
// No backpressure: req is sampled only at frame boundaries and ocupado flags a command in flight.
module bus_datos_rtc
  import bus_datos_rtc_pkg::*;
(
  input  logic       reloj,
  input  logic       resetM,
  input  logic       sync,
  input  logic [4:0] cont_32,
  input  logic       enable_cont_32,
  input  logic       LE,
  input  logic       req,
  input  logic [7:0] dir_in,
  input  logic [7:0] dato_in,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic [7:0] dato_leido,
  output logic       dato_valido,
  output logic       ocupado,
  output logic       hecho
);

  estado_t    estado, estado_sig;
  logic       acepta;
  logic       captura;
  logic [7:0] dir_lat;
  logic [7:0] dato_lat;
  logic       le_lat;

  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      estado <= IDLE;
    end else begin
      estado <= estado_sig;
    end
  end

  // FIN doubles as an acceptance point so back-to-back commands skip the idle frame.
  always_comb begin
    estado_sig = estado;
    acepta     = 1'b0;
    case (estado)
      IDLE: begin
        if (enable_cont_32 && req) begin
          acepta     = 1'b1;
          estado_sig = DIRECCION;
        end
      end
      DIRECCION: begin
        if (cont_32 == DIR_FIN) estado_sig = ESPERA;
      end
      ESPERA: begin
        if (cont_32 == DATO_INI - 5'd1) estado_sig = DATO;
      end
      DATO: begin
        if (cont_32 == DATO_FIN) estado_sig = FIN;
      end
      FIN: begin
        if (enable_cont_32) begin
          if (req) begin
            acepta     = 1'b1;
            estado_sig = DIRECCION;
          end else begin
            estado_sig = IDLE;
          end
        end
      end
      default: estado_sig = IDLE;
    endcase
    if (sync) begin
      estado_sig = IDLE;
      acepta     = 1'b0;
    end
  end

  assign captura = (estado == DATO) && le_lat && (cont_32 == MUESTRA) && !sync;
  assign hecho   = (estado == FIN) && enable_cont_32 && !sync;
  assign ocupado = (estado != IDLE);

  // Reads never enable the pad in DATO, keeping the bus free while the RTC drives it.
  always_comb begin
    ad_out = 8'h00;
    ad_oe  = 1'b0;
    if (estado == DIRECCION && en_ventana(cont_32, DIR_INI, DIR_FIN)) begin
      ad_out = dir_lat;
      ad_oe  = 1'b1;
    end else if (estado == DATO && !le_lat && en_ventana(cont_32, DATO_INI, DATO_FIN)) begin
      ad_out = dato_lat;
      ad_oe  = 1'b1;
    end
  end

  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      dir_lat     <= 8'h00;
      dato_lat    <= 8'h00;
      le_lat      <= 1'b0;
      dato_leido  <= 8'h00;
      dato_valido <= 1'b0;
    end else begin
      dato_valido <= captura;
      if (captura) dato_leido <= ad_in;
      if (acepta) begin
        dir_lat  <= dir_in;
        dato_lat <= dato_in;
        le_lat   <= LE;
      end
    end
  end

endmodule

// File: tb/tb_bus_datos_rtc.sv
// Bench for bus_datos_rtc: directed commands against a frame generator, expected bus events queued and matched by a negedge monitor.
module tb_bus_datos_rtc;

  logic       reloj = 1'b0;
  logic       resetM = 1'b1;
  logic       sync = 1'b0;
  logic [4:0] cont_32 = 5'd31;
  logic       enable_cont_32 = 1'b0;
  logic       LE = 1'b0;
  logic       req = 1'b0;
  logic [7:0] dir_in = 8'h00;
  logic [7:0] dato_in = 8'h00;
  logic [7:0] ad_in = 8'h00;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] dato_leido;
  logic       dato_valido;
  logic       ocupado;
  logic       hecho;

  typedef enum int {BUS, LEIDO, HECHO} tipo_t;
  typedef struct {
    tipo_t tipo;
    int    trama;
    int    cont;
    int    val;
  } ev_t;

  ev_t esperado[$];
  int  n_eval = 0;
  int  n_fail = 0;
  int  trama = 0;

  bus_datos_rtc dut (
    .reloj(reloj), .resetM(resetM), .sync(sync), .cont_32(cont_32),
    .enable_cont_32(enable_cont_32), .LE(LE), .req(req), .dir_in(dir_in),
    .dato_in(dato_in), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .dato_leido(dato_leido), .dato_valido(dato_valido), .ocupado(ocupado),
    .hecho(hecho)
  );

  initial forever #5 reloj = ~reloj;

  // Frame generator: free-running 0..31, boundary pulse with cont_32 = 0.
  initial forever begin
    @(posedge reloj);
    #1;
    cont_32 = cont_32 + 5'd1;
    enable_cont_32 = (cont_32 == 5'd0);
    if (enable_cont_32) trama++;
  end

  function automatic void poner(tipo_t t, int tr, int c, int v);
    esperado.push_back(ev_t'{t, tr, c, v});
  endfunction

  function automatic void encolar(int n, logic le, int dir, int dat, int leido,
                                  int ultimo_dir, bit completo);
    for (int c = 1; c <= ultimo_dir; c++) poner(BUS, n, c, dir);
    if (completo) begin
      if (!le) begin
        for (int c = 19; c <= 28; c++) poner(BUS, n, c, dat);
      end else begin
        poner(LEIDO, n, 27, leido);
      end
      poner(HECHO, n + 1, 0, 0);
    end
  endfunction

  function automatic void revisar(tipo_t t, int v);
    ev_t e;
    n_eval++;
    if (esperado.size() == 0) begin
      n_fail++;
      $display("FAIL evento_inesperado: got %s trama=%0d cont=%0d val=%02h, required no event",
               t.name(), trama, cont_32, v);
    end else begin
      e = esperado.pop_front();
      if (e.tipo != t || e.trama != trama || e.cont != int'(cont_32) || e.val != v) begin
        n_fail++;
        $display("FAIL evento: got %s trama=%0d cont=%0d val=%02h, required %s trama=%0d cont=%0d val=%02h",
                 t.name(), trama, cont_32, v, e.tipo.name(), e.trama, e.cont, e.val);
      end
    end
  endfunction

  always @(negedge reloj) begin
    if (!resetM) begin
      if (ad_oe)       revisar(BUS, int'(ad_out));
      if (dato_valido) revisar(LEIDO, int'(dato_leido));
      if (hecho)       revisar(HECHO, 0);
    end
  end

  task automatic chequear(input string nombre, input logic [31:0] act, input logic [31:0] req_v);
    n_eval++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nombre, act, req_v);
    end
  endtask

  task automatic ir_a(input int n, input int c);
    for (int i = 0; i < 5000; i++) begin
      if (trama == n && int'(cont_32) == c) return;
      @(posedge reloj);
      #2;
    end
    n_eval++;
    n_fail++;
    $display("FAIL timeout_ir_a: got trama=%0d cont=%0d, required trama=%0d cont=%0d",
             trama, cont_32, n, c);
  endtask

  task automatic chequear_reset(input string etiqueta);
    chequear({etiqueta, "_ad_oe"}, ad_oe, 0);
    chequear({etiqueta, "_ad_out"}, ad_out, 0);
    chequear({etiqueta, "_dato_leido"}, dato_leido, 0);
    chequear({etiqueta, "_dato_valido"}, dato_valido, 0);
    chequear({etiqueta, "_ocupado"}, ocupado, 0);
    chequear({etiqueta, "_hecho"}, hecho, 0);
  endtask

  initial begin
    int n;
    #2;
    chequear_reset("reset_inicial");
    repeat (3) @(posedge reloj);
    #2;
    resetM = 1'b0;

    // Write 0x21 / 0x45; inputs scrambled after acceptance.
    n = trama + 1;
    ir_a(n, 0);
    LE = 1'b0; dir_in = 8'h21; dato_in = 8'h45; req = 1'b1;
    encolar(n, 1'b0, 'h21, 'h45, 0, 11, 1'b1);
    ir_a(n, 2);
    req = 1'b0; dir_in = 8'hDE; dato_in = 8'hAD; LE = 1'b1;
    ir_a(n, 15);
    chequear("ocupado_escritura", ocupado, 1);
    ir_a(n + 1, 1);
    chequear("ocupado_tras_hecho", ocupado, 0);

    // Read at 0xF0; only the value present at cont 26 may be captured.
    n = trama + 1;
    ir_a(n, 0);
    LE = 1'b1; dir_in = 8'hF0; req = 1'b1; ad_in = 8'h55;
    encolar(n, 1'b1, 'hF0, 0, 'h3A, 11, 1'b1);
    ir_a(n, 2);
    req = 1'b0;
    ir_a(n, 26);
    ad_in = 8'h3A;
    ir_a(n, 27);
    ad_in = 8'hC3;
    ir_a(n + 1, 1);
    chequear("dato_leido_lectura", dato_leido, 'h3A);

    // Late request raised at cont 3 waits for the next boundary.
    ir_a(trama, 3);
    req = 1'b1; LE = 1'b0; dir_in = 8'h5C; dato_in = 8'hA7;
    n = trama + 1;
    encolar(n, 1'b0, 'h5C, 'hA7, 0, 11, 1'b1);
    ir_a(n - 1, 20);
    chequear("ocupado_peticion_tardia", ocupado, 0);
    ir_a(n, 2);
    req = 1'b0; dir_in = 8'hFF; dato_in = 8'h00; LE = 1'b1;
    ir_a(n + 1, 1);
    chequear("ocupado_fin_tardia", ocupado, 0);

    // Back-to-back: write then read with req held across the boundary.
    n = trama + 1;
    ir_a(n, 0);
    LE = 1'b0; dir_in = 8'h11; dato_in = 8'h22; req = 1'b1;
    encolar(n, 1'b0, 'h11, 'h22, 0, 11, 1'b1);
    ir_a(n, 2);
    LE = 1'b1; dir_in = 8'h33; dato_in = 8'h99;
    encolar(n + 1, 1'b1, 'h33, 0, 'h6B, 11, 1'b1);
    ir_a(n + 1, 1);
    chequear("ocupado_sin_trama_libre", ocupado, 1);
    ir_a(n + 1, 2);
    req = 1'b0;
    ir_a(n + 1, 26);
    ad_in = 8'h6B;
    ir_a(n + 1, 27);
    ad_in = 8'h00;
    ir_a(n + 2, 1);
    chequear("dato_leido_b2b", dato_leido, 'h6B);
    chequear("ocupado_fin_b2b", ocupado, 0);

    // sync coinciding with the boundary blocks acceptance.
    n = trama + 1;
    ir_a(n, 0);
    req = 1'b1; sync = 1'b1; LE = 1'b0; dir_in = 8'h77;
    ir_a(n, 1);
    chequear("ocupado_sync_enable", ocupado, 0);
    req = 1'b0; sync = 1'b0;

    // Abort a read at cont 22.
    n = trama + 1;
    ir_a(n, 0);
    LE = 1'b1; dir_in = 8'hF0; req = 1'b1; ad_in = 8'h3A;
    encolar(n, 1'b1, 'hF0, 0, 0, 11, 1'b0);
    ir_a(n, 2);
    req = 1'b0;
    ir_a(n, 22);
    sync = 1'b1;
    ir_a(n, 23);
    sync = 1'b0;
    chequear("ocupado_tras_sync", ocupado, 0);
    chequear("ad_oe_tras_sync", ad_oe, 0);
    ir_a(n + 1, 2);
    chequear("dato_leido_conservado", dato_leido, 'h6B);

    // Asynchronous reset at cont 5 of a write.
    n = trama + 1;
    ir_a(n, 0);
    LE = 1'b0; dir_in = 8'h9D; dato_in = 8'h4E; req = 1'b1;
    encolar(n, 1'b0, 'h9D, 'h4E, 0, 4, 1'b0);
    ir_a(n, 2);
    req = 1'b0;
    ir_a(n, 5);
    resetM = 1'b1;
    #1;
    chequear_reset("reset_async");
    repeat (2) @(posedge reloj);
    #2;
    resetM = 1'b0;
    ir_a(trama + 2, 1);
    chequear("ocupado_tras_reset", ocupado, 0);
    chequear("eventos_pendientes", esperado.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got no end of test, required completion before 200000");
    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
